// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that grants one functional-unit result per cycle onto the registered CDB
module cdb_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W+TAG_W:0]     cdb_out
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, win;
    logic                  found, xfer;
    logic [DATA_W+TAG_W:0] cdb_q, cdb_d;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Search from rr_ptr upward; iterating backwards lets the closest valid requester win last
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr_q, k)]) begin
                win   = wrap_idx(rr_ptr_q, k);
                found = 1'b1;
            end
        end
    end

    // Grant, broadcast capture and pointer advance; flush and reset suppress any transfer
    always_comb begin
        xfer      = found & ~flush & reset_n;
        req_ready = '0;
        if (xfer) req_ready[win] = 1'b1;
        cdb_d     = xfer ? {1'b1, req_data[int'(win)*DATA_W +: DATA_W], req_tag[int'(win)*TAG_W +: TAG_W]}
                         : {1'b0, cdb_q[DATA_W+TAG_W-1:0]};
        rr_ptr_d  = flush ? '0 : xfer ? ((win == LAST) ? '0 : win + 1'b1) : rr_ptr_q;
    end

    // State registers with asynchronous clear so a reset kills an in-flight broadcast at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_out = cdb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random checks of grant order, CDB contents, flush and reset
module tb_cdb_arbiter;
    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset_n, flush;
    logic [N-1:0]  req_valid;
    logic [N*16-1:0] req_data;
    logic [N*3-1:0]  req_tag;
    logic [N-1:0]  req_ready;
    logic [19:0]   cdb_out;

    int          n_cmp = 0, n_err = 0;
    int          m_ptr = 0;
    logic [18:0] last = '0;
    logic [19:0] sb[$];
    int          g;
    int          wt[N];

    cdb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .req_valid(req_valid),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready), .cdb_out(cdb_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check grant at mid-cycle against the model, then the CDB just after the edge
    task automatic step(input string name, output int w);
        logic [N-1:0] er;
        logic [19:0]  e;
        @(negedge clk);
        w = -1;
        if (!flush)
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk({name, " ready"}, 32'(req_ready), 32'(er));
        chk({name, " onehot"}, 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
        if (flush) m_ptr = 0;
        else if (w >= 0) begin
            sb.push_back({1'b1, req_data[w*16 +: 16], req_tag[w*3 +: 3]});
            m_ptr = (w == N - 1) ? 0 : w + 1;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            last = e[18:0];
        end else e = {1'b0, last};
        chk({name, " cdb"}, 32'(cdb_out), 32'(e));
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_data[i*16 +: 16] = 16'hA000 + 16'(i);
            req_tag[i*3 +: 3]    = 3'(i);
        end
        #2;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset cdb", 32'(cdb_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset cdb held", 32'(cdb_out), 32'd0);
        reset_n = 1'b1;

        for (int c = 0; c < 7; c++) step("rr", g);

        req_valid = 6'b000100;
        req_data[2*16 +: 16] = 16'hBEEF;
        req_tag[2*3 +: 3]    = 3'd5;
        step("single", g);
        req_valid = '0;
        step("single idle", g);

        req_valid = 6'b010000;
        step("to ptr5", g);
        req_valid = 6'b001010;
        step("wrap a", g);
        chk("wrap a winner", 32'(g), 32'd1);
        step("wrap b", g);
        chk("wrap b winner", 32'(g), 32'd3);
        step("wrap c", g);
        chk("wrap c winner", 32'(g), 32'd1);

        req_valid = 6'b010000;
        flush     = 1'b1;
        step("flush", g);
        flush     = 1'b0;
        req_valid = 6'b010001;
        step("post flush", g);
        chk("post flush winner", 32'(g), 32'd0);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset cdb", 32'(cdb_out), 32'd0);
        chk("async reset ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ptr   = 0;
        last    = '0;
        sb.delete();
        req_valid = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*16 +: 16] = 16'($urandom);
                    req_tag[i*3 +: 3]    = 3'($urandom);
                    wt[i]                = 0;
                end
            step("rand", g);
            if (g >= 0) begin
                chk("starve", 32'(wt[g] < N), 32'd1);
                req_valid[g] = 1'b0;
            end
            for (int i = 0; i < N; i++) if (req_valid[i]) wt[i]++;
        end

        for (int c = 0; c < N + 1 && req_valid != '0; c++) begin
            step("drain", g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        chk("drain empty", 32'(req_valid), 32'd0);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
